// File: rtl/tlp_seq_scheduler.sv
// tlp_seq_scheduler: compacts arbiter grants into sequence-recorder writes and
// replays popped sources to the fragmentation engine in recorder order.
module tlp_seq_scheduler #(
  parameter int FIFO_DEPTH  = 257,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int SRC_W       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [3:0]              arb_src_valid,
  input  logic [4*SRC_W-1:0]      arb_src_id,
  output logic                    arb_ready,
  output logic                    rec_wr_en,
  output logic [2:0]              rec_wr_mode,
  output logic [SRC_W-1:0]        rec_wr_data_1,
  output logic [SRC_W-1:0]        rec_wr_data_2,
  output logic [SRC_W-1:0]        rec_wr_data_3,
  output logic [SRC_W-1:0]        rec_wr_data_4,
  output logic                    rec_rd_en,
  output logic [1:0]              rec_rd_mode,
  input  logic [SRC_W-1:0]        rec_rd_data_1,
  input  logic [SRC_W-1:0]        rec_rd_data_2,
  input  logic [ADDR_WIDTH:0]     rec_available,
  input  logic                    rec_full,
  input  logic                    rec_empty,
  output logic                    frag_req_valid,
  output logic [SRC_W-1:0]        frag_req_src,
  input  logic                    frag_req_ready,
  input  logic                    frag_done,
  output logic                    start_fragment,
  output logic                    busy,
  output logic                    err_no_source,
  output logic                    err_timeout
);
  localparam logic [SRC_W-1:0]    NO_SOURCE = '0;
  localparam int                  TW        = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]       T_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH     = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, ISSUE_A = 3'd2, WAIT_A = 3'd3, ISSUE_B = 3'd4, WAIT_B = 3'd5;
  logic [2:0]        state, nxt, after_a;
  logic [SRC_W-1:0]  slot_a, slot_b, cur_slot;
  logic              mode_two, issuing, waiting, wait_end;
  logic [TW-1:0]     timer;
  logic [ADDR_WIDTH:0] occ;
  logic [SRC_W-1:0]  wd [4];
  logic [2:0]        n;
  always_comb begin
    wd = '{default: NO_SOURCE};
    n  = 3'd0;
    for (int i = 0; i < 4; i++)
      if (arb_src_valid[i]) begin
        wd[n[1:0]] = arb_src_id[i*SRC_W +: SRC_W];
        n = n + 3'd1;
      end
  end
  assign arb_ready     = !rec_full && rec_available >= (ADDR_WIDTH + 1)'(4);
  assign rec_wr_en     = arb_ready && |arb_src_valid;
  assign rec_wr_mode   = n;
  assign rec_wr_data_1 = wd[0];
  assign rec_wr_data_2 = wd[1];
  assign rec_wr_data_3 = wd[2];
  assign rec_wr_data_4 = wd[3];
  assign occ            = DEPTH - rec_available;
  assign rec_rd_en      = state == IDLE && !rec_empty;
  assign rec_rd_mode    = !rec_rd_en ? 2'd0 : occ >= (ADDR_WIDTH + 1)'(2) ? 2'd2 : 2'd1;
  assign issuing        = state == ISSUE_A || state == ISSUE_B;
  assign waiting        = state == WAIT_A || state == WAIT_B;
  assign cur_slot       = state == ISSUE_B ? slot_b : slot_a;
  assign frag_req_valid = issuing && cur_slot != NO_SOURCE;
  assign frag_req_src   = frag_req_valid ? cur_slot : NO_SOURCE;
  assign start_fragment = frag_req_valid && frag_req_ready;
  assign busy           = state != IDLE;
  // the watchdog expiring is treated exactly like a late frag_done
  assign wait_end       = waiting && (frag_done || timer == T_LAST);
  assign after_a        = slot_b != NO_SOURCE ? ISSUE_B : IDLE;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = rec_rd_en ? LOAD : IDLE;
      LOAD:    nxt = ISSUE_A;
      ISSUE_A: nxt = slot_a == NO_SOURCE ? after_a : frag_req_ready ? WAIT_A : ISSUE_A;
      WAIT_A:  nxt = wait_end ? after_a : WAIT_A;
      ISSUE_B: nxt = slot_b == NO_SOURCE ? IDLE : frag_req_ready ? WAIT_B : ISSUE_B;
      WAIT_B:  nxt = wait_end ? IDLE : WAIT_B;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state         <= IDLE;
      slot_a        <= NO_SOURCE;
      slot_b        <= NO_SOURCE;
      mode_two      <= 1'b0;
      timer         <= '0;
      err_no_source <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state <= nxt;
      if (rec_rd_en) mode_two <= rec_rd_mode == 2'd2;
      if (state == LOAD) begin
        slot_a <= rec_rd_data_1;
        slot_b <= mode_two ? rec_rd_data_2 : NO_SOURCE;
      end
      if (issuing && cur_slot == NO_SOURCE) err_no_source <= 1'b1;
      timer <= start_fragment ? '0 : waiting ? timer + TW'(1) : timer;
      if (waiting && !frag_done && timer == T_LAST) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tlp_seq_scheduler.sv
// tb_tlp_seq_scheduler: directed vectors with a scoreboard of expected pops and requests.
module tb_tlp_seq_scheduler;
  logic        clk = 0, arst = 1;
  logic [3:0]  arb_src_valid = 0;
  logic [11:0] arb_src_id = 0;
  logic        arb_ready, rec_wr_en, rec_rd_en, frag_req_valid, start_fragment, busy, err_no_source, err_timeout;
  logic [2:0]  rec_wr_mode, rec_wr_data_1, rec_wr_data_2, rec_wr_data_3, rec_wr_data_4, frag_req_src;
  logic [1:0]  rec_rd_mode;
  logic [2:0]  rec_rd_data_1 = 0, rec_rd_data_2 = 0;
  logic [9:0]  rec_available, avail_val = 10'd257;
  logic        rec_full, rec_empty, full_ovr = 0, avail_ovr = 1;
  logic        frag_req_ready = 1, frag_done = 0, done_en = 1;
  int          checks = 0, failures = 0, n_start = 0, wr_tot = 0, rd_tot = 0, cnt = 0;
  logic [2:0]  mem [64];
  logic [2:0]  exp_src [$];
  logic [1:0]  exp_mode [$];

  tlp_seq_scheduler #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .arst(arst), .arb_src_valid(arb_src_valid), .arb_src_id(arb_src_id),
    .arb_ready(arb_ready), .rec_wr_en(rec_wr_en), .rec_wr_mode(rec_wr_mode),
    .rec_wr_data_1(rec_wr_data_1), .rec_wr_data_2(rec_wr_data_2),
    .rec_wr_data_3(rec_wr_data_3), .rec_wr_data_4(rec_wr_data_4),
    .rec_rd_en(rec_rd_en), .rec_rd_mode(rec_rd_mode),
    .rec_rd_data_1(rec_rd_data_1), .rec_rd_data_2(rec_rd_data_2),
    .rec_available(rec_available), .rec_full(rec_full), .rec_empty(rec_empty),
    .frag_req_valid(frag_req_valid), .frag_req_src(frag_req_src),
    .frag_req_ready(frag_req_ready), .frag_done(frag_done),
    .start_fragment(start_fragment), .busy(busy),
    .err_no_source(err_no_source), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  assign rec_available = avail_ovr ? avail_val : 10'(257 - (wr_tot - rd_tot));
  assign rec_empty     = wr_tot == rd_tot;
  assign rec_full      = full_ovr;

  // recorder read side: registered data one cycle after rd_en
  always @(posedge clk)
    if (rec_rd_en) begin
      rec_rd_data_1 <= mem[rd_tot];
      rec_rd_data_2 <= rec_rd_mode == 2'd2 ? mem[rd_tot + 1] : 3'd0;
      rd_tot        <= rd_tot + int'(rec_rd_mode);
    end

  // fragmentation engine: done pulse two cycles after each accepted request
  always @(posedge clk)
    if (arst) begin
      cnt <= 0;
      frag_done <= 0;
    end else begin
      cnt       <= (start_fragment && done_en) ? 2 : (cnt > 0 ? cnt - 1 : 0);
      frag_done <= cnt == 1;
    end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk)
    if (!arst) begin
      if (start_fragment) begin
        n_start++;
        if (exp_src.size() == 0) chk("unexpected_start", 1, 0);
        else chk("frag_req_src", int'(frag_req_src), int'(exp_src.pop_front()));
      end
      if (rec_rd_en) begin
        if (exp_mode.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("rec_rd_mode", int'(rec_rd_mode), int'(exp_mode.pop_front()));
      end
    end

  task automatic load(input logic [2:0] a, input logic [2:0] b, input int n);
    @(posedge clk); #1;
    mem[wr_tot] = a;
    if (n == 2) mem[wr_tot + 1] = b;
    wr_tot = wr_tot + n;
  endtask

  task automatic wait_idle();
    int i = 0;
    @(posedge clk); @(negedge clk);
    while ((busy || !rec_empty) && i < 200) begin @(negedge clk); i++; end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_start();
    int i = 0;
    @(negedge clk);
    while (!start_fragment && i < 100) begin @(negedge clk); i++; end
    chk("start_seen", int'(start_fragment), 1);
  endtask

  task automatic wr_vec(input logic [3:0] v, input logic [11:0] id, input int mode,
                        input int d1, input int d2, input int d3, input int d4);
    @(posedge clk); #1;
    arb_src_valid = v; arb_src_id = id;
    @(negedge clk);
    chk("wr_mode", int'(rec_wr_mode), mode);
    chk("wr_d1", int'(rec_wr_data_1), d1);
    chk("wr_d2", int'(rec_wr_data_2), d2);
    chk("wr_d3", int'(rec_wr_data_3), d3);
    chk("wr_d4", int'(rec_wr_data_4), d4);
  endtask

  initial begin
    int s0;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1 arst = 0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_req_valid", int'(frag_req_valid), 0);
    chk("rst_req_src", int'(frag_req_src), 0);
    chk("rst_start", int'(start_fragment), 0);
    chk("rst_rd_en", int'(rec_rd_en), 0);
    chk("rst_rd_mode", int'(rec_rd_mode), 0);
    chk("rst_err_ns", int'(err_no_source), 0);
    chk("rst_err_to", int'(err_timeout), 0);
    // write path: lanes {1,2,3,4}
    wr_vec(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 4, 1, 2, 3, 4);
    chk("wr_ready_257", int'(arb_ready), 1);
    chk("wr_en_full_grant", int'(rec_wr_en), 1);
    wr_vec(4'b0101, {3'd7, 3'd3, 3'd5, 3'd6}, 2, 6, 3, 0, 0);
    wr_vec(4'b1010, {3'd2, 3'd6, 3'd5, 3'd7}, 2, 5, 2, 0, 0);
    wr_vec(4'b1000, {3'd3, 3'd1, 3'd1, 3'd1}, 1, 3, 0, 0, 0);
    @(posedge clk); #1 avail_val = 10'd3;
    @(negedge clk);
    chk("ready_avail3", int'(arb_ready), 0);
    chk("wr_en_avail3", int'(rec_wr_en), 0);
    @(posedge clk); #1 avail_val = 10'd4;
    @(negedge clk);
    chk("ready_avail4", int'(arb_ready), 1);
    @(posedge clk); #1 full_ovr = 1;
    @(negedge clk);
    chk("ready_full", int'(arb_ready), 0);
    chk("wr_en_full", int'(rec_wr_en), 0);
    @(posedge clk); #1 full_ovr = 0; arb_src_valid = 0; avail_ovr = 0;
    @(negedge clk);
    chk("wr_en_no_valid", int'(rec_wr_en), 0);
    // pair {5,7}
    s0 = n_start;
    exp_mode.push_back(2'd2); exp_src.push_back(3'd5); exp_src.push_back(3'd7);
    load(3'd5, 3'd7, 2);
    wait_idle();
    chk("pair_starts", n_start - s0, 2);
    chk("pair_err_ns", int'(err_no_source), 0);
    // single {4}
    s0 = n_start;
    exp_mode.push_back(2'd1); exp_src.push_back(3'd4);
    load(3'd4, 3'd0, 1);
    wait_idle();
    chk("single_starts", n_start - s0, 1);
    // pair {0,3}: empty slot skipped
    s0 = n_start;
    exp_mode.push_back(2'd2); exp_src.push_back(3'd3);
    load(3'd0, 3'd3, 2);
    wait_idle();
    chk("nosrc_starts", n_start - s0, 1);
    chk("nosrc_err", int'(err_no_source), 1);
    // watchdog
    done_en = 0;
    exp_mode.push_back(2'd1); exp_src.push_back(3'd6);
    load(3'd6, 3'd0, 1);
    wait_start();
    repeat (16) @(negedge clk);
    chk("timeout_early", int'(err_timeout), 0);
    @(negedge clk);
    chk("timeout_set", int'(err_timeout), 1);
    chk("timeout_advance", int'(busy), 0);
    // reset while waiting
    exp_mode.push_back(2'd1); exp_src.push_back(3'd2);
    load(3'd2, 3'd0, 1);
    wait_start();
    repeat (3) @(negedge clk);
    chk("midwait_busy", int'(busy), 1);
    @(posedge clk); #1 arst = 1;
    @(posedge clk); @(negedge clk);
    chk("arst_busy", int'(busy), 0);
    chk("arst_req_valid", int'(frag_req_valid), 0);
    chk("arst_req_src", int'(frag_req_src), 0);
    chk("arst_start", int'(start_fragment), 0);
    chk("arst_err_ns", int'(err_no_source), 0);
    chk("arst_err_to", int'(err_timeout), 0);
    @(posedge clk); #1 arst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    chk("sb_src_drained", exp_src.size(), 0);
    chk("sb_mode_drained", exp_mode.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
